// File: rtl/apb_dual_master_ctrl_if.sv
// Requester handshakes and the shared APB bus of apb_dual_master_ctrl.
// master: the controller's view. slave: the requesters' and slaves' view.
interface apb_dual_master_ctrl_if;
    logic       req0_valid;
    logic       req0_write;
    logic [7:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req0_ready;
    logic       req0_done;
    logic       req0_err;
    logic [7:0] req0_rdata;

    logic       req1_valid;
    logic       req1_write;
    logic [7:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       req1_ready;
    logic       req1_done;
    logic       req1_err;
    logic [7:0] req1_rdata;

    logic       PSEL1;
    logic       PSEL2;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA1;
    logic [7:0] PRDATA2;
    logic       PREADY;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_err, req1_rdata,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA1, PRDATA2, PREADY
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_err, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_err, req1_rdata,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA1, PRDATA2, PREADY
    );
endinterface

// File: rtl/apb_dual_master_ctrl.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// slave decode on addr[7], per-requester completion with wait-state timeout.
// Every output is a register; the comb block computes their next values.
module apb_dual_master_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    apb_dual_master_ctrl_if.master        bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // Last wait count before abort: the TIMEOUT-th low-PREADY cycle aborts.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_d;
    logic       rr_ptr, rr_ptr_d;       // requester that wins the next tie
    logic       owner, owner_d;         // requester of the transfer in flight
    logic [7:0] wait_cnt, wait_cnt_d;

    logic [1:0] ready_q, ready_d;
    logic [1:0] done_q, done_d;
    logic [1:0] err_q, err_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       psel1_q, psel1_d;
    logic       psel2_q, psel2_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;

    logic       v0, v1, grant_any, grant_id;
    logic       g_write;
    logic [7:0] g_addr, g_wdata;
    logic       launch, finish;
    logic [7:0] cap_data;

    // Arbitration; the in-flight owner's valid is ignored until its done.
    always_comb begin
        v0        = bus.req0_valid && !(state == ACCESS && owner == 1'b0);
        v1        = bus.req1_valid && !(state == ACCESS && owner == 1'b1);
        grant_any = v0 || v1;
        grant_id  = (v0 && v1) ? rr_ptr : v1;
        g_write   = grant_id ? bus.req1_write : bus.req0_write;
        g_addr    = grant_id ? bus.req1_addr  : bus.req0_addr;
        g_wdata   = grant_id ? bus.req1_wdata : bus.req0_wdata;
    end

    // Next state and next register values for all outputs.
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        owner_d    = owner;
        wait_cnt_d = wait_cnt;
        ready_d    = '0;
        done_d     = '0;
        err_d      = '0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        psel1_d    = psel1_q;
        psel2_d    = psel2_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        launch     = 1'b0;
        finish     = 1'b0;
        cap_data   = paddr_q[7] ? bus.PRDATA2 : bus.PRDATA1;

        case (state)
            IDLE: launch = grant_any;
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    done_d[owner] = 1'b1;
                    if (!pwrite_q) begin
                        if (owner) rdata1_d = cap_data;
                        else       rdata0_d = cap_data;
                    end
                    launch = grant_any;
                    finish = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abort never chains into a new transfer.
                    done_d[owner] = 1'b1;
                    err_d[owner]  = 1'b1;
                    if (owner) rdata1_d = 8'h00;
                    else       rdata0_d = 8'h00;
                    finish = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d             = SETUP;
            owner_d             = grant_id;
            rr_ptr_d            = ~grant_id;
            ready_d[grant_id]   = 1'b1;
            pwrite_d            = g_write;
            paddr_d             = g_addr;
            pwdata_d            = g_wdata;
            psel1_d             = ~g_addr[7];
            psel2_d             = g_addr[7];
            penable_d           = 1'b0;
        end else if (finish) begin
            state_d   = IDLE;
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            owner    <= owner_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    // Output registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_err   = err_q[0];
    assign bus.req1_err   = err_q[1];
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;
    assign bus.PSEL1      = psel1_q;
    assign bus.PSEL2      = psel2_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
endmodule
